// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, captures the combinational instruction-memory word into IF/ID,
// handles freeze/branch redirect. Optional program-halt detection under `HALT_DETECT_EN.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hEAFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic        halted
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;

`ifdef HALT_DETECT_EN
  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  state_e state_q, state_d;
  logic   unused_addr_bits;

  assign unused_addr_bits = ^branch_addr[1:0];
`else
  logic [33:0] unused_bits;

  // Halt word is fetched like any other word in this build.
  assign unused_bits = {branch_addr[1:0], HALT_WORD};
`endif

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;
`ifdef HALT_DETECT_EN
    state_d       = state_q;
    if (state_q == ST_HALT) begin
      if_valid_d = 1'b0;
    end else
`endif
    if (branch_taken) begin
      pc_d       = {branch_addr[31:2], 2'b00};
      if_valid_d = 1'b0;
      if_instr_d = '0;
    end else if (!freeze) begin
      pc_d          = pc_plus4;
      if_pc_d       = pc_plus4;
      if_instr_d    = imem_data;
      if_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
`ifdef HALT_DETECT_EN
      if (imem_data == HALT_WORD) begin
        state_d = ST_HALT;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: random freeze/branch traffic against a
// behavioural fetch model; honours `HALT_DETECT_EN like the design.
module tb_instruction_fetch_stage;

  localparam logic [31:0] HALT = 32'hEAFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic        halted;

  logic [31:0] halt_addr;

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(32'hEAFF_FFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .fetch_count (fetch_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory image: a scrambled function of the address, with the halt word at halt_addr only.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ha);
    logic [31:0] w;
    if (a == ha) return HALT;
    w = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    if (w == HALT) w = w ^ 32'd1;
    return w;
  endfunction

  always_comb imem_data = mem_word(imem_addr, halt_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
  logic        m_valid, m_halted;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = '0; m_instr = '0; m_cnt = '0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock of stimulus; expected post-edge state is queued for the monitor.
  task automatic step(input bit f, input bit b, input logic [31:0] a);
    logic [31:0] w;
    @(negedge clk);
    freeze = f; branch_taken = b; branch_addr = a;
    if (m_halted) begin
      m_valid = 1'b0;
    end else if (b) begin
      m_pc = a & ~32'd3;
      m_valid = 1'b0;
      m_instr = '0;
    end else if (!f) begin
      w = mem_word(m_pc, halt_addr);
      m_instr = w;
      m_ifpc = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
`ifdef HALT_DETECT_EN
      if (w == HALT) m_halted = 1'b1;
`endif
    end
    q.push_back('{pc: m_pc, ifpc: m_ifpc, instr: m_instr, cnt: m_cnt,
                  valid: m_valid, halted: m_halted});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_fetch_count"}, fetch_count, 32'h0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("imem_addr", imem_addr, e.pc);
      chk("if_pc", if_pc, e.ifpc);
      chk("if_instr", if_instr, e.instr);
      chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
      chk("fetch_count", fetch_count, e.cnt);
      chk("halted", {31'd0, halted}, {31'd0, e.halted});
    end
  end

  initial begin
    logic [31:0] a;
    bit          f, b;
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    halt_addr = 32'h0000_0001;
    model_reset();
    #3 check_reset_outputs("por");
    @(posedge clk);
    #2 rst = 1'b1;

    // Sequential advance, freeze at pc=12, branch overriding freeze, wrap.
    repeat (3) step(0, 0, '0);
    step(1, 0, '0);
    step(1, 0, '0);
    step(0, 0, '0);
    step(1, 1, 32'h0000_0073);
    step(0, 0, '0);
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, '0);
    step(0, 0, '0);

    // Mid-run reset with pc at 0x40.
    step(0, 1, 32'h0000_0040);
    async_reset("arst1");

    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(3) == 0);
      b = ($urandom_range(5) == 0);
      case ($urandom_range(3))
        0: a = $urandom_range(255);
        1: a = 32'hFFFF_FFF0 | $urandom_range(15);
        2: a = $urandom;
        default: a = 32'h0000_0040;
      endcase
      step(f, b, a);
    end

    // Halt word at 0xB8, then traffic that must be ignored while halted.
    halt_addr = 32'h0000_00B8;
    step(0, 1, 32'h0000_00B0);
    repeat (3) step(0, 0, '0);
    step(0, 0, '0);
    step(0, 1, 32'h0000_00B8);
    step(1, 1, 32'h0000_0010);
    step(1, 0, '0);
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(1) == 1, $urandom_range(2) == 0, 32'h0000_00B8);
    end

    async_reset("arst2");
    halt_addr = 32'h0000_0001;
    repeat (4) step(0, 0, '0);

    @(posedge clk);
    #2;
    chk("sb_drain", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Consumer side of the byte-addressed, little-endian instruction memory in the ARM pipeline.
- Owns the PC, drives the memory address and captures the returned 32-bit word into the IF/ID pipeline register.
- Handles hazard freeze and branch redirect from EX.
- Provides fetch bookkeeping: a fetch counter and a halt flag raised when the fetched word is the program-terminating "B #-1".

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- HALT_WORD, 32'hEAFF_FFFF, encoding of "B #-1" (cond AL, B, offset -1) that terminates a program.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- freeze  in  1  hazard stall from the hazard unit; hold PC and IF/ID.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- branch_addr  in  32  branch target byte address.
- imem_addr  out  32  byte address to instruction memory; equals the current PC (combinational).
- imem_data  in  32  combinational word from memory: {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
- if_pc  out  32  registered PC+4 of the captured instruction.
- if_instr  out  32  registered instruction word.
- if_valid  out  1  IF/ID holds a live instruction.
- fetch_count  out  32  number of words accepted into IF/ID.
- halted  out  1  halt word accepted; fetching stopped.

Behaviour:
- Reset, asynchronous on rst=0, regardless of current state:
  - pc=RESET_PC, if_pc=0, if_instr=0, if_valid=0, fetch_count=0, halted=0, FSM=RUN.
- PC register: pc[1:0] is always 00; branch_addr[1:0] is ignored (forced to 00). pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- imem_addr = pc. Memory read is combinational, so the word is captured at the same edge that advances pc. Fetch latency is 1 cycle (address to if_instr).
- FSM states:
  - RUN: normal fetching.
  - HALT: terminal; left only by reset.
- RUN, priority order, evaluated per rising edge:
  1. branch_taken=1:
     - pc <= {branch_addr[31:2],2'b00}; if_valid <= 0; if_instr <= 0; if_pc unchanged.
     - fetch_count unchanged. Overrides freeze when both are asserted.
  2. freeze=1: pc, if_pc, if_instr, if_valid, fetch_count all hold.
  3. Otherwise (accept):
     - pc <= pc+4; if_pc <= pc+4; if_instr <= imem_data; if_valid <= 1; fetch_count <= fetch_count+1 (wraps).
     - If imem_data==HALT_WORD: FSM <= HALT, halted <= 1. The halt word itself is captured with if_valid=1 so it flows downstream once.
- HALT:
  - pc, if_pc, if_instr and fetch_count hold; halted=1.
  - if_valid <= 0 on the first HALT edge and stays 0.
  - freeze and branch_taken are ignored, including the self-branch the halt word later resolves to in EX.
- Outputs are registered except imem_addr.
- if_instr=0 with if_valid=0 is a bubble; downstream gates on if_valid.

Optional Feature:
- Macro HALT_DETECT_EN.
- Defined: HALT state, the halted port behaviour and halt-word comparison exactly as above.
- Undefined:
  - No HALT state; halted is tied to 0.
  - HALT_WORD is fetched like any other word: pc keeps advancing, and the downstream branch redirects the fetch loop.
  - Port list is unchanged.

Test Plan:
- Reset/advance: rst=0 then release, memory holds sequential words, freeze=0, branch_taken=0 -> imem_addr 0,4,8,...; first edge gives if_pc=4, if_instr=mem word 0, if_valid=1; fetch_count=3 after 3 edges.
- Freeze: assert freeze for 2 cycles at pc=12 -> pc stays 12, IF/ID and fetch_count unchanged; release -> if_instr=word at 12, if_pc=16.
- Branch beats freeze: freeze=1 and branch_taken=1 with branch_addr=32'h0000_0073 at the same edge -> pc=32'h70, if_valid=0, fetch_count unchanged; next edge fetches from 0x70.
- Wrap: branch to 32'hFFFF_FFFC, then an accept edge -> if_pc=0, pc=0.
- Halt (HALT_DETECT_EN defined): word at 0xB8 = 32'hEAFF_FFFF -> accepted with if_valid=1; next edge halted=1, if_valid=0, pc=0xBC. Later branch_taken with branch_addr=0xB8 is ignored. Without the macro: pc=0xB8 again, fetch continues, halted=0.
- Async reset mid-run: drop rst between edges while pc=0x40 -> all outputs reset immediately without waiting for a clock edge; halted cleared.
